// File: rtl/counter_pkg.sv
// Shared definitions for the counter library.
// Holds the down-timer state encoding and the default datapath width so the
// timer controller, its datapath and any neighbouring counters agree on them.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    PAUSED = 2'd3
  } timer_state_t;

endpackage

// File: rtl/down_timer_dp.sv
// Datapath of the down-counting timer: count register, reload register,
// zero compare and decrement. All sequencing decisions come from the
// controller; this block only applies the one operation it is told to do.
//
// Ports:
//   clk_i       rising-edge clock
//   clear_n_i   asynchronous active-low reset (count and reload to 0)
//   preset_i    force count and reload to PRESET_VAL
//   load_i      load count and reload from load_data_i
//   load_data_i start/reload value
//   reload_i    copy reload register into count
//   dec_i       decrement count by one
//   count_o     current count
//   zero_o      count is zero
module down_timer_dp #(
  parameter int               WIDTH      = counter_pkg::DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             clear_n_i,
  input  logic             preset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             reload_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge clk_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  // The controller never asserts more than one command per cycle, but the
  // chain still encodes preset > load > reload > decrement so the datapath
  // is well defined on its own.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (preset_i) begin
      count_d  = PRESET_VAL;
      reload_d = PRESET_VAL;
    end else if (load_i) begin
      count_d  = load_data_i;
      reload_d = load_data_i;
    end else if (reload_i) begin
      count_d  = reload_q;
    end else if (dec_i) begin
      count_d  = count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/down_timer_ctrl.sv
// Loadable down-counting timer with terminal-count pulse and optional
// auto-reload. Serves as the timeout/period generator beside the loadable
// up-counter. A load value N produces a terminal event every N+1 ticks.
//
// Ports:
//   clk          rising-edge clock
//   clear_n      asynchronous active-low reset
//   pre          synchronous preset of count and reload to PRESET_VAL
//   load_valid   load request; accepted when load_ready is high
//   load_ready   high whenever the timer is not running
//   load_data    start/reload value
//   start        begin or resume counting
//   stop         pause counting
//   tick         count-enable strobe
//   auto_reload  reload on the terminal event instead of going idle
//   count        current count
//   busy         high while running
//   tc_pulse     one-cycle pulse after each terminal event
module down_timer_ctrl
  import counter_pkg::*;
#(
  parameter int               WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             pre,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse
);

  timer_state_t state_q, state_d;
  logic         tc_q, tc_d;

  logic dpPreset, dpLoad, dpReload, dpDec;
  logic countZero;
  logic loadAccept;

  down_timer_dp #(
    .WIDTH      (WIDTH),
    .PRESET_VAL (PRESET_VAL)
  ) u_dp (
    .clk_i       (clk),
    .clear_n_i   (clear_n),
    .preset_i    (dpPreset),
    .load_i      (dpLoad),
    .load_data_i (load_data),
    .reload_i    (dpReload),
    .dec_i       (dpDec),
    .count_o     (count),
    .zero_o      (countZero)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign load_ready = (state_q != RUN);
  assign loadAccept = load_valid && load_ready;

  // Priority pre > load > stop > start > tick. Because a load can only be
  // accepted outside RUN, and tick only matters inside RUN, the lower
  // priorities are resolved per state. tc_d stays low on any cycle that
  // pre wins, which cancels a terminal event landing on the same edge.
  always_comb begin
    state_d  = state_q;
    tc_d     = 1'b0;
    dpPreset = 1'b0;
    dpLoad   = 1'b0;
    dpReload = 1'b0;
    dpDec    = 1'b0;
    if (pre) begin
      dpPreset = 1'b1;
      state_d  = LOADED;
    end else if (loadAccept) begin
      dpLoad  = 1'b1;
      state_d = LOADED;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOADED, PAUSED: begin
          if (start && !stop) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSED;
          end else if (tick) begin
            // A tick at zero is the terminal event rather than a wrap.
            if (countZero) begin
              tc_d = 1'b1;
              if (auto_reload) dpReload = 1'b1;
              else             state_d  = IDLE;
            end else begin
              dpDec = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Self-checking bench for down_timer_ctrl: directed scenarios followed by a
// randomized run compared against a behavioural model of the timer.
module tb_down_timer_ctrl;

  localparam int M_IDLE    = 0;
  localparam int M_LOADED  = 1;
  localparam int M_RUN     = 2;
  localparam int M_PAUSED  = 3;
  localparam logic [7:0] PRESET = 8'hFF;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       pre = 1'b0;
  logic       loadValid = 1'b0;
  logic       loadReady;
  logic [7:0] loadData = 8'h00;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tick = 1'b0;
  logic       autoReload = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic       tcPulse;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: mode, current count, reload value and pulse output
  int         mMode = M_IDLE;
  logic [7:0] mCount = 8'h00;
  logic [7:0] mReload = 8'h00;
  logic       mTc = 1'b0;

  down_timer_ctrl #(
    .WIDTH      (8),
    .PRESET_VAL (8'hFF)
  ) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .pre         (pre),
    .load_valid  (loadValid),
    .load_ready  (loadReady),
    .load_data   (loadData),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .auto_reload (autoReload),
    .count       (count),
    .busy        (busy),
    .tc_pulse    (tcPulse)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    logic terminal;
    terminal = 1'b0;
    if (pre) begin
      mCount  = PRESET;
      mReload = PRESET;
      mMode   = M_LOADED;
    end else if (loadValid && mMode != M_RUN) begin
      mCount  = loadData;
      mReload = loadData;
      mMode   = M_LOADED;
    end else if (mMode == M_RUN) begin
      if (stop) begin
        mMode = M_PAUSED;
      end else if (tick) begin
        if (mCount == 8'd0) begin
          terminal = 1'b1;
          if (autoReload) mCount = mReload;
          else            mMode  = M_IDLE;
        end else begin
          mCount = mCount - 8'd1;
        end
      end
    end else if ((mMode == M_LOADED || mMode == M_PAUSED) && start && !stop) begin
      mMode = M_RUN;
    end
    mTc = terminal;
  endtask

  task automatic modelReset();
    mMode   = M_IDLE;
    mCount  = 8'h00;
    mReload = 8'h00;
    mTc     = 1'b0;
  endtask

  // Drive one cycle of inputs, update the model, and land #1 after the edge.
  task automatic applyStimulus(input logic iPre, input logic iLv, input logic [7:0] iLd,
                               input logic iStart, input logic iStop, input logic iTick,
                               input logic iAr);
    pre        = iPre;
    loadValid  = iLv;
    loadData   = iLd;
    start      = iStart;
    stop       = iStop;
    tick       = iTick;
    autoReload = iAr;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clear_n = 1'b0;
    pre = 1'b0; loadValid = 1'b0; loadData = 8'h00;
    start = 1'b0; stop = 1'b0; tick = 1'b0; autoReload = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    #1;
    modelReset();
    testsRun++;
    if (count !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset_count: got %0h expected 0", count);
    end
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_busy: got %0b expected 0", busy);
    end
    testsRun++;
    if (loadReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_load_ready: got %0b expected 1", loadReady);
    end
    testsRun++;
    if (tcPulse !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_tc: got %0b expected 0", tcPulse);
    end
    doReset();
  endtask

  task automatic test_oneshot();
    logic [7:0] expCount [3] = '{8'h02, 8'h01, 8'h00};
    applyStimulus(0, 1, 8'h03, 0, 0, 0, 0);
    testsRun++;
    if (count !== 8'h03 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_load: got count=%0h busy=%0b expected count=3 busy=0", count, busy);
    end
    applyStimulus(0, 0, 8'h00, 1, 0, 1, 0);
    testsRun++;
    if (busy !== 1'b1 || count !== 8'h03) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_start: got count=%0h busy=%0b expected count=3 busy=1", count, busy);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 1, 0);
      testsRun++;
      if (count !== expCount[i] || tcPulse !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL oneshot_tick%0d: got count=%0h tc=%0b expected count=%0h tc=0",
                 i, count, tcPulse, expCount[i]);
      end
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 0);
    testsRun++;
    if (tcPulse !== 1'b1 || busy !== 1'b0 || count !== 8'h00 || loadReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_terminal: got tc=%0b busy=%0b count=%0h ready=%0b expected 1 0 0 1",
               tcPulse, busy, count, loadReady);
    end
    applyStimulus(0, 0, 8'h00, 1, 0, 1, 0);
    testsRun++;
    if (tcPulse !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_after: got tc=%0b busy=%0b expected tc=0 busy=0", tcPulse, busy);
    end
  endtask

  task automatic test_auto_reload();
    logic       expTc;
    logic [7:0] expCnt;
    applyStimulus(0, 1, 8'h02, 0, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 1, 1);
      expTc  = (k % 3 == 0);
      expCnt = (k % 3 == 1) ? 8'h01 : ((k % 3 == 2) ? 8'h00 : 8'h02);
      testsRun++;
      if (tcPulse !== expTc || count !== expCnt || busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL autoreload_tick%0d: got tc=%0b count=%0h busy=%0b expected tc=%0b count=%0h busy=1",
                 k, tcPulse, count, busy, expTc, expCnt);
      end
    end
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_stop_resume();
    applyStimulus(0, 1, 8'h05, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 1, 1, 0);
    testsRun++;
    if (count !== 8'h05 || busy !== 1'b0 || loadReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stop_with_tick: got count=%0h busy=%0b ready=%0b expected 5 0 1",
               count, busy, loadReady);
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 0);
    testsRun++;
    if (count !== 8'h05 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL paused_tick: got count=%0h busy=%0b expected 5 0", count, busy);
    end
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    testsRun++;
    if (busy !== 1'b1 || count !== 8'h05) begin
      testsFailed++;
      $display("[TB] FAIL resume: got busy=%0b count=%0h expected 1 5", busy, count);
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 0);
    testsRun++;
    if (count !== 8'h04) begin
      testsFailed++;
      $display("[TB] FAIL resume_tick: got count=%0h expected 4", count);
    end
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_preset();
    applyStimulus(0, 1, 8'h07, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0, 1, 0);
    testsRun++;
    if (count !== PRESET || busy !== 1'b0 || loadReady !== 1'b1 || tcPulse !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL preset_run: got count=%0h busy=%0b ready=%0b tc=%0b expected ff 0 1 0",
               count, busy, loadReady, tcPulse);
    end
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 1, 8'h11, 0, 0, 0, 0);
    testsRun++;
    if (count !== PRESET || loadReady !== 1'b0 || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL load_in_run: got count=%0h ready=%0b busy=%0b expected ff 0 1",
               count, loadReady, busy);
    end
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0);
    // Terminal tick on the same edge as pre must not produce a pulse.
    applyStimulus(0, 1, 8'h00, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0, 1, 1);
    testsRun++;
    if (tcPulse !== 1'b0 || count !== PRESET || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL preset_cancels_tc: got tc=%0b count=%0h busy=%0b expected 0 ff 0",
               tcPulse, count, busy);
    end
  endtask

  task automatic test_zero_reload();
    applyStimulus(0, 1, 8'h00, 0, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 1, 1);
      testsRun++;
      if (tcPulse !== 1'b1 || count !== 8'h00 || busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL zero_reload_tick%0d: got tc=%0b count=%0h busy=%0b expected 1 0 1",
                 k, tcPulse, count, busy);
      end
    end
    // Reset asserted between edges: outputs must clear without a clock.
    #1;
    clear_n = 1'b0;
    #1;
    modelReset();
    testsRun++;
    if (tcPulse !== 1'b0 || count !== 8'h00 || busy !== 1'b0 || loadReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got tc=%0b count=%0h busy=%0b ready=%0b expected 0 0 0 1",
               tcPulse, count, busy, loadReady);
    end
    doReset();
  endtask

  task automatic test_random();
    logic       rPre, rLv, rStart, rStop, rTick, rAr;
    logic [7:0] rLd;
    logic       expBusy, expReady;
    for (int c = 0; c < 2000; c++) begin
      rPre   = ($urandom_range(0, 31) == 0);
      rLv    = ($urandom_range(0, 3) == 0);
      rLd    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      rStart = ($urandom_range(0, 3) == 0);
      rStop  = ($urandom_range(0, 11) == 0);
      rTick  = ($urandom_range(0, 2) != 0);
      rAr    = ($urandom_range(0, 1) == 0);
      applyStimulus(rPre, rLv, rLd, rStart, rStop, rTick, rAr);
      expBusy  = (mMode == M_RUN);
      expReady = (mMode != M_RUN);
      testsRun++;
      if (count !== mCount || busy !== expBusy || loadReady !== expReady || tcPulse !== mTc) begin
        testsFailed++;
        $display("[TB] FAIL random_cycle%0d: got count=%0h busy=%0b ready=%0b tc=%0b expected count=%0h busy=%0b ready=%0b tc=%0b",
                 c, count, busy, loadReady, tcPulse, mCount, expBusy, expReady, mTc);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_stop_resume();
    test_preset();
    test_zero_reload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/down_timer_ctrl.md
Name: down_timer_ctrl

Overview:
- Loadable down-counting timer that complements the existing loadable up-counter.
- Accepts a start value through a valid/ready load port and counts down on qualified `tick` strobes.
- Emits a one-cycle terminal-count pulse and optionally auto-reloads.
- Sits beside the up-counter in the counter library as the timeout/period generator for the same datapaths.

Parameters:
- WIDTH, 8, bit width of count and load value.
- PRESET_VAL, {WIDTH{1'b1}}, value forced into count and reload registers by `pre`.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- clear_n  in  1  asynchronous active-low reset.
- pre  in  1  synchronous preset; highest priority after reset.
- load_valid  in  1  load request.
- load_ready  out  1  load accepted when load_valid & load_ready.
- load_data  in  WIDTH  start/reload value.
- start  in  1  begin or resume counting.
- stop  in  1  pause counting.
- tick  in  1  count-enable strobe, one decrement per cycle when high.
- auto_reload  in  1  level; sampled at the terminal event.
- count  out  WIDTH  current count, registered.
- busy  out  1  high in RUN.
- tc_pulse  out  1  one-cycle registered pulse at the terminal event.

Behaviour:
- Interface decided: one clock `clk`; reset `clear_n` is asynchronous, active-low.
- Reset values: count=0, reload register=0, state=IDLE, tc_pulse=0, busy=0, load_ready=1.
- States:
  - IDLE: load_ready=1. An accepted load sets count and reload to load_data, then goes to LOADED. start is ignored.
  - LOADED: load_ready=1. A new load overwrites count and reload and stays in LOADED. start goes to RUN next cycle; the first decrement can occur on the cycle after start.
  - RUN: load_ready=0, busy=1.
    - tick with count!=0: count<=count-1.
    - tick with count==0 (terminal event): tc_pulse=1 on the next cycle.
    - At the terminal event, if auto_reload=1: count<=reload, stay in RUN.
    - At the terminal event, if auto_reload=0: count stays 0, go to IDLE.
    - stop goes to PAUSED, count held.
  - PAUSED: load_ready=1. start returns to RUN. An accepted load sets count/reload and goes to LOADED. stop is ignored.
- Period: load value N gives a terminal event every N+1 ticks in RUN.
  - N=0 with auto_reload gives tc_pulse on every tick.
- Priority within a cycle: pre > accepted load > stop > start > tick.
  - pre: count and reload <= PRESET_VAL, go to LOADED, any pending terminal pulse cancelled.
  - stop and tick together in RUN: tick dropped, count unchanged.
  - start and stop together: stop wins (RUN goes to PAUSED; LOADED stays LOADED).
- Decrement is modulo 2^WIDTH internally, but wrap never occurs because count==0 is intercepted as the terminal event.
- tc_pulse is never high for two consecutive cycles unless two consecutive terminal events occur (ticks every cycle with reload 0).
- Reset mid-RUN: all registers return to reset values immediately, asynchronously; no tc_pulse is produced.
- load_valid while load_ready=0 is ignored. The requester must hold it until accepted; no buffering.

Decomposition:
- Shared package counter_pkg holds:
  - state enum typedef timer_state_t {IDLE, LOADED, RUN, PAUSED}, 2-bit encoding;
  - default WIDTH constant.
- One sub-module is natural: down_timer_dp. It contains the count and reload registers, the zero compare and the decrement.
- The FSM and tc_pulse register stay in down_timer_ctrl.

Test Plan:
- Reset then load 8'h03, start, tick every cycle → count 3,2,1,0; tc_pulse high exactly one cycle after the tick at count 0; state returns to IDLE, busy=0.
- Load 8'h02, auto_reload=1, tick every cycle for 9 ticks → tc_pulse on ticks 3, 6 and 9; count reloads to 2 after each pulse.
- RUN at count 5, assert stop with tick → count stays 5, busy=0, load_ready=1; start → resumes, next tick gives 4.
- RUN at count 7, assert pre and tick together → count=8'hFF, state LOADED, no tc_pulse; load_valid during RUN → load_ready=0, count unaffected.
- Load 0, auto_reload=1, start, tick continuously → tc_pulse every cycle; deassert clear_n mid-run → count=0, tc_pulse=0 asynchronously.
